// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with run/pause/reload control and seven-segment decode.
// Optional macro EXPIRE_BLINK_EN makes the expiry LED blink at TICK_HZ while the timer is done.
module bcd_countdown_timer #(
   parameter int          CLK_HZ  = 12000000,
   parameter int          TICK_HZ = 1,
   parameter int          DIGITS  = 2,
   parameter logic [15:0] PRESET  = 16'h0024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_pause,
   input  logic                  reload,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [9*DIGITS-1:0]   seg_led,
   output logic                  running,
   output logic                  expired,
   output logic [7:0]            led
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam int BW  = 4 * DIGITS;

   localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
   localparam logic [BW-1:0] PRESET_V = PRESET[BW-1:0];

   localparam logic [1:0] ST_LOADED = 2'd0;
   localparam logic [1:0] ST_RUN    = 2'd1;
   localparam logic [1:0] ST_PAUSE  = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [BW-1:0] bcd_q, bcd_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick;
   logic [BW-1:0] bcdDec;

   // Ripple-borrow decrement: a zero digit wraps to 9 and passes the borrow upward.
   function automatic logic [BW-1:0] decrementBcd(input logic [BW-1:0] v);
      logic [BW-1:0] r;
      logic          borrow;
      logic [3:0]    d;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (borrow) begin
            if (d == 4'd0) begin
               r[4*i +: 4] = 4'd9;
               borrow      = 1'b1;
            end else begin
               r[4*i +: 4] = d - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [6:0] segDecode(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'h3F;
         4'd1:    p = 7'h06;
         4'd2:    p = 7'h5B;
         4'd3:    p = 7'h4F;
         4'd4:    p = 7'h66;
         4'd5:    p = 7'h6D;
         4'd6:    p = 7'h7D;
         4'd7:    p = 7'h07;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h6F;
         default: p = 7'h00;
      endcase
      return p;
   endfunction

   assign tick   = (state_q == ST_RUN) && (presc_q == DIV_LAST);
   assign bcdDec = decrementBcd(bcd_q);

   // A tick landing on a pause pulse still decrements; reaching zero beats pausing.
   always_comb begin
      state_d = state_q;
      bcd_d   = bcd_q;
      presc_d = '0;
      case (state_q)
         ST_LOADED: begin
            if (start_pause) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bcd_q == '0) begin
               state_d = ST_DONE;
            end else begin
               if (tick) bcd_d = bcdDec;
               if (tick && (bcdDec == '0)) begin
                  state_d = ST_DONE;
               end else if (start_pause) begin
                  state_d = ST_PAUSE;
               end else begin
                  presc_d = tick ? '0 : presc_q + PW'(1);
               end
            end
         end
         ST_PAUSE: begin
            if (start_pause) state_d = ST_RUN;
         end
         default: begin
            state_d = ST_DONE;
         end
      endcase
      if (reload) begin
         state_d = ST_LOADED;
         bcd_d   = PRESET_V;
         presc_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_LOADED;
         bcd_q   <= PRESET_V;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         presc_q <= presc_d;
      end
   end

   assign bcd     = bcd_q;
   assign running = (state_q == ST_RUN);
   assign expired = (state_q == ST_DONE);

   for (genvar g = 0; g < DIGITS; g++) begin : gSeg
      assign seg_led[9*g +: 9] = {2'b00, segDecode(bcd_q[4*g +: 4])};
   end

`ifdef EXPIRE_BLINK_EN
   localparam int HALF = DIV / 2;
   localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);

   logic [HW-1:0] blinkCnt_q, blinkCnt_d;
   logic          blinkPhase_q, blinkPhase_d;

   // Blink counter idles at zero outside DONE so every expiry starts with the LED lit.
   always_comb begin
      blinkCnt_d   = '0;
      blinkPhase_d = 1'b0;
      if (state_q == ST_DONE) begin
         if (blinkCnt_q == HALF_LAST) begin
            blinkCnt_d   = '0;
            blinkPhase_d = ~blinkPhase_q;
         end else begin
            blinkCnt_d   = blinkCnt_q + HW'(1);
            blinkPhase_d = blinkPhase_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blinkCnt_q   <= '0;
         blinkPhase_q <= 1'b0;
      end else begin
         blinkCnt_q   <= blinkCnt_d;
         blinkPhase_q <= blinkPhase_d;
      end
   end

   assign led = ((state_q == ST_DONE) && !blinkPhase_q) ? 8'h00 : 8'hFF;
`else
   assign led = (state_q == ST_DONE) ? 8'h00 : 8'hFF;
`endif

endmodule
